// File: rtl/spi_byte_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : spi_byte_master                                             |
// | Description: Byte-wide full-duplex SPI master, mode 0, single chip       |
// |              select. MSB first by default; defining                      |
// |              SPI_MASTER_LSB_FIRST_EN switches both directions to LSB     |
// |              first.                                                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module spi_byte_master #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       buzy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  // Counter must reach 2*HALF_PERIOD-1 for the HOLD phase.
  localparam int c_CNT_W = $clog2(2 * HALF_PERIOD + 1);
  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(HALF_PERIOD - 1);
  // HOLD lasts one full sclk period so cs rises 18 half-periods after start.
  localparam logic [c_CNT_W-1:0] c_HOLD_M1 = c_CNT_W'(2 * HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

`ifdef SPI_MASTER_LSB_FIRST_EN
  // LSB first: transmit from bit 0, shift right; receive fills from the top.
  function automatic logic first_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] b, input logic in);
    return {in, b[7:1]};
  endfunction
`else
  // MSB first: transmit from bit 7, shift left; receive enters at bit 0.
  function automatic logic first_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] b, input logic in);
    return {b[6:0], in};
  endfunction
`endif

  state_t                 state_q, state_d;
  logic [c_CNT_W-1:0]     hcnt_q, hcnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   last_q, last_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             dout_q, dout_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_q, cs_d;
  logic                   buzy_q, buzy_d;
  logic                   done_q, done_d;
  logic                   start_q;

  // State and datapath registers; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      bit_cnt_q <= 3'd0;
      last_q    <= 1'b0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      dout_q    <= 8'h00;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      buzy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      buzy_q    <= buzy_d;
      done_q    <= done_d;
      start_q   <= start;
    end
  end

  // Next-state logic: half-period timer drives sclk edges, shifting and framing.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    buzy_d    = buzy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d   = S_SETUP;
          tx_d      = data_in;
          rx_d      = 8'h00;
          mosi_d    = first_bit(data_in);
          cs_d      = 1'b0;
          buzy_d    = 1'b1;
          hcnt_d    = '0;
          bit_cnt_d = 3'd0;
          last_d    = 1'b0;
        end
      end

      S_SETUP: begin
        if (hcnt_q == c_HALF_M1) begin
          // First rising edge: sample the first incoming bit.
          hcnt_d    = '0;
          sclk_d    = 1'b1;
          rx_d      = rx_shift(rx_q, miso);
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = S_SHIFT;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (hcnt_q == c_HALF_M1) begin
          hcnt_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit, or finish after bit 8.
            sclk_d = 1'b0;
            if (last_q) begin
              mosi_d  = 1'b0;
              state_d = S_HOLD;
            end else begin
              tx_d   = tx_shift(tx_q);
              mosi_d = first_bit(tx_shift(tx_q));
            end
          end else begin
            // Rising edge: capture miso; terminal flag stops a 9th bit.
            sclk_d    = 1'b1;
            rx_d      = rx_shift(rx_q, miso);
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              last_d = 1'b1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (hcnt_q == c_HOLD_M1) begin
          hcnt_d  = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          dout_d  = rx_q;
          buzy_d  = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign buzy     = buzy_q;
  assign done     = done_q;
  assign data_out = dout_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_spi_byte_master                                          |
// | Description: Directed self-checking bench for spi_byte_master (default  |
// |              MSB-first build, HALF_PERIOD = 2).                          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_spi_byte_master;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       buzy;
  logic       done;
  logic [7:0] data_out;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int n_tests;
  int n_fail;
  int cyc;
  int rise_cnt;
  int done_cnt;
  logic [7:0] mosi_cap;

  // Slave model state.
  logic       loop_en;
  logic [7:0] slave_byte;
  logic       slave_bit;
  int         sbit;

  spi_byte_master #(.HALF_PERIOD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .buzy     (buzy),
    .done     (done),
    .data_out (data_out),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe every sclk rise: count it and capture the bit on mosi.
  always @(posedge sclk) begin
    rise_cnt++;
    mosi_cap = {mosi_cap[6:0], mosi};
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Mode-0 slave: first bit on cs fall, next bit on every sclk fall.
  always @(negedge cs) begin
    sbit      = 7;
    slave_bit = slave_byte[7];
  end

  always @(negedge sclk) begin
    if (cs === 1'b0) begin
      sbit = sbit - 1;
      if (sbit >= 0) slave_bit = slave_byte[sbit];
    end
  end

  assign miso = loop_en ? mosi : slave_bit;

  // One byte transfer; returns received byte, start-to-done latency, timeout.
  task automatic xfer(input logic [7:0] din, input logic [7:0] resp,
                      output logic [7:0] dout, output int lat, output bit tmo);
    int t0;
    tmo = 1'b1;
    lat = 0;
    @(negedge clk);
    rise_cnt   = 0;
    mosi_cap   = 8'h00;
    slave_byte = resp;
    data_in    = din;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
    lat  = cyc - t0;
    dout = data_out;
    n_tests++;
    if (tmo) begin
      n_fail++;
      $display("FAIL xfer_timeout: no done within 100 cycles for data_in=%h", din);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cs, sclk, buzy, done, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got cs=%b sclk=%b buzy=%b done=%b dout=%h, need 1 0 0 0 00",
                 i, cs, sclk, buzy, done, data_out);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    int lat;
    bit tmo;
    int d0;
    loop_en = 1'b1;
    d0 = done_cnt;
    xfer(8'h00, 8'h00, d, lat, tmo);
    @(negedge clk);
    n_tests++;
    if (rise_cnt !== 8) begin
      n_fail++;
      $display("FAIL loop_rises: got %0d, need 8", rise_cnt);
    end
    n_tests++;
    if (lat !== 36) begin
      n_fail++;
      $display("FAIL loop_latency: got %0d, need 36", lat);
    end
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL loop_data00: got %h, need 00", d);
    end
    n_tests++;
    if (done_cnt !== d0 + 1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_done_once: got %0d pulses done=%b, need 1 and 0", done_cnt - d0, done);
    end
    xfer(8'hA5, 8'h00, d, lat, tmo);
    n_tests++;
    if (d !== 8'hA5) begin
      n_fail++;
      $display("FAIL loop_dataA5: got %h, need a5", d);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_slave;
    logic [7:0] d;
    int lat;
    bit tmo;
    xfer(8'h3C, 8'h69, d, lat, tmo);
    n_tests++;
    if (mosi_cap !== 8'h3C) begin
      n_fail++;
      $display("FAIL slave_mosi: got %h, need 3c", mosi_cap);
    end
    n_tests++;
    if (d !== 8'h69) begin
      n_fail++;
      $display("FAIL slave_miso: got %h, need 69", d);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (data_out !== 8'h69 || cs !== 1'b1 || buzy !== 1'b0) begin
      n_fail++;
      $display("FAIL slave_hold: got dout=%h cs=%b buzy=%b, need 69 1 0", data_out, cs, buzy);
    end
  endtask

  task automatic test_held_start;
    logic [7:0] d;
    int lat;
    bit tmo;
    int d0;
    loop_en = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    data_in = 8'hC3;
    start   = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++;
    if (done_cnt !== d0 + 1 || buzy !== 1'b0 || cs !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_one: got %0d transfers buzy=%b cs=%b, need 1 0 1", done_cnt - d0, buzy, cs);
    end
    start = 1'b0;
    xfer(8'h5A, 8'h00, d, lat, tmo);
    @(negedge clk);
    n_tests++;
    if (done_cnt !== d0 + 2 || d !== 8'h5A) begin
      n_fail++;
      $display("FAIL held_start_second: got %0d transfers dout=%h, need 2 5a", done_cnt - d0, d);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_reset_abort;
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    @(negedge clk);
    rise_cnt   = 0;
    slave_byte = 8'hFF;
    data_in    = 8'h81;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rise_cnt == 4) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_wait: got %0d rises, need 4", rise_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({cs, sclk, buzy, data_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_state: got cs=%b sclk=%b buzy=%b dout=%h, need 1 0 0 00", cs, sclk, buzy, data_out);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (done_cnt !== d0 || data_out !== 8'h00 || rise_cnt !== 4) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses dout=%h rises=%0d, need 0 00 4",
               done_cnt - d0, data_out, rise_cnt);
    end
  endtask

  task automatic test_burst;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] tx_seen;
    logic [127:0] rx_seen;
    logic [7:0]   d;
    int lat;
    bit tmo;
    pt = 128'h00112233445566778899aabbccddeeff;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tx_seen = '0;
    rx_seen = '0;
    for (int i = 0; i < 16; i++) begin
      xfer(pt[127 - 8*i -: 8], ct[127 - 8*i -: 8], d, lat, tmo);
      if (tmo) break;
      tx_seen = {tx_seen[119:0], mosi_cap};
      rx_seen = {rx_seen[119:0], d};
      n_tests++;
      if (lat !== 36) begin
        n_fail++;
        $display("FAIL burst_latency byte %0d: got %0d, need 36", i, lat);
      end
    end
    n_tests++;
    if (tx_seen !== pt) begin
      n_fail++;
      $display("FAIL burst_mosi: got %h, need %h", tx_seen, pt);
    end
    n_tests++;
    if (rx_seen !== ct) begin
      n_fail++;
      $display("FAIL burst_miso: got %h, need %h", rx_seen, ct);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    rise_cnt   = 0;
    done_cnt   = 0;
    mosi_cap   = 8'h00;
    loop_en    = 1'b0;
    slave_byte = 8'h00;
    slave_bit  = 1'b0;
    sbit       = 0;
    reset      = 1'b1;
    start      = 1'b0;
    data_in    = 8'h00;

    test_reset();
    test_loopback();
    test_slave();
    test_held_start();
    test_reset_abort();
    test_burst();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
